// File: rtl/ppu_pixel_pipe_if.sv
// rtl/ppu_pixel_pipe_if.sv - pixel stream, pattern control, palette write and RGB output bundle
interface ppu_pixel_pipe_if #(
  parameter int COLOR_BITS   = 8,
  parameter int NUM_PALETTES = 2
);
  localparam int BANK_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
  localparam int RGB_W  = 3 * COLOR_BITS;

  logic              px_en;
  logic [5:0]        px_data;
  logic [2:0]        emph;
  logic              frame_sync;
  logic [2:0]        mode_req;
  logic [BANK_W-1:0] pal_sel_req;
  logic [5:0]        test_color;
  logic              pal_we;
  logic [5+BANK_W:0] pal_waddr;
  logic [RGB_W-1:0]  pal_wdata;
  logic [RGB_W-1:0]  rgb;
  logic              rgb_valid;
  logic [8:0]        px_x;
  logic [8:0]        px_y;

  modport master (
    output px_en, px_data, emph, frame_sync, mode_req, pal_sel_req, test_color,
           pal_we, pal_waddr, pal_wdata,
    input  rgb, rgb_valid, px_x, px_y
  );

  modport slave (
    input  px_en, px_data, emph, frame_sync, mode_req, pal_sel_req, test_color,
           pal_we, pal_waddr, pal_wdata,
    output rgb, rgb_valid, px_x, px_y
  );
endinterface

// File: rtl/ppu_pixel_pipe.sv
// rtl/ppu_pixel_pipe.sv - PPU index to RGB pipe with test patterns, 2-cycle latency
// Optional EMPHASIS_EN adds emphasis attenuation.
module ppu_pixel_pipe #(
  parameter int COLOR_BITS    = 8,
  parameter int NUM_PALETTES  = 2,
  parameter int SCREEN_WIDTH  = 256,
  parameter int SCREEN_HEIGHT = 240
) (
  input logic             clk,
  input logic             rst_n,
  ppu_pixel_pipe_if.slave bus
);
  localparam int CB     = COLOR_BITS;
  localparam int RGB_W  = 3 * CB;
  localparam int BANK_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
  localparam int AW     = 6 + $clog2(NUM_PALETTES);
  localparam logic [8:0] X_LAST = 9'(SCREEN_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(SCREEN_HEIGHT - 1);

  logic [RGB_W-1:0] pal_mem [NUM_PALETTES*64];

  logic [8:0]        x_q, x_d, y_q, y_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [2:0]        mode_q, mode_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              s1_valid_q, s1_valid_d, s1_raw_q, s1_raw_d;
  logic [5:0]        s1_idx_q, s1_idx_d;
  logic [RGB_W-1:0]  s1_raw_rgb_q, s1_raw_rgb_d;
  logic [BANK_W-1:0] s1_bank_q, s1_bank_d;
  logic [8:0]        s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              rgb_valid_q, rgb_valid_d;
  logic [8:0]        px_x_q, px_x_d, px_y_q, px_y_d;

  logic [8:0]        cur_x, cur_y;
  logic [5:0]        cur_fc;
  logic [2:0]        cur_mode;
  logic [AW-1:0]     rd_addr;
  logic [RGB_W-1:0]  color;

`ifdef EMPHASIS_EN
  logic [2:0] s1_emph_q, s1_emph_d;

  function automatic logic [CB-1:0] atten(input logic [CB-1:0] c);
    return c - (c >> 2);
  endfunction
`else
  logic unused_emph;
  assign unused_emph = ^bus.emph;
`endif

  // Read-first: the stage-2 read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (bus.pal_we) pal_mem[AW'(bus.pal_waddr)] <= bus.pal_wdata;
  end

  always_comb begin
    // A frame_sync pixel is (0,0) of the new frame with the newly requested mode/bank.
    cur_x    = bus.frame_sync ? 9'd0 : x_q;
    cur_y    = bus.frame_sync ? 9'd0 : y_q;
    cur_fc   = bus.frame_sync ? frame_cnt_q[5:0] + 6'd1 : frame_cnt_q[5:0];
    cur_mode = bus.frame_sync ? bus.mode_req : mode_q;

    x_d         = cur_x;
    y_d         = cur_y;
    frame_cnt_d = bus.frame_sync ? frame_cnt_q + 8'd1 : frame_cnt_q;
    mode_d      = cur_mode;
    bank_d      = bus.frame_sync ? bus.pal_sel_req : bank_q;
    if (bus.px_en) begin
      if (cur_x == X_LAST) begin
        x_d = 9'd0;
        y_d = (cur_y == Y_LAST) ? 9'd0 : cur_y + 9'd1;
      end else begin
        x_d = cur_x + 9'd1;
      end
    end

    s1_valid_d   = bus.px_en;
    s1_raw_d     = s1_raw_q;
    s1_idx_d     = s1_idx_q;
    s1_raw_rgb_d = s1_raw_rgb_q;
    s1_bank_d    = s1_bank_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
`ifdef EMPHASIS_EN
    s1_emph_d    = s1_emph_q;
`endif
    if (bus.px_en) begin
      s1_raw_d     = (cur_mode == 3'd1);
      s1_raw_rgb_d = {bus.px_data[5:4], {(CB-2){1'b0}},
                      bus.px_data[3:2], {(CB-2){1'b0}},
                      bus.px_data[1:0], {(CB-2){1'b0}}};
      s1_bank_d    = bank_d;
      s1_x_d       = cur_x;
      s1_y_d       = cur_y;
`ifdef EMPHASIS_EN
      s1_emph_d    = bus.emph;
`endif
      case (cur_mode)
        3'd2:    s1_idx_d = bus.test_color;
        3'd3:    s1_idx_d = {cur_x[7:5], 3'b000};
        3'd4:    s1_idx_d = (cur_x[3:0] == 4'd0 || cur_y[3:0] == 4'd0) ? 6'h30 : 6'h0F;
        3'd5:    s1_idx_d = cur_x[7:2] + cur_fc;
        default: s1_idx_d = bus.px_data;
      endcase
    end

    rd_addr = AW'({s1_bank_q, s1_idx_q});
    color   = s1_raw_q ? s1_raw_rgb_q : pal_mem[rd_addr];
`ifdef EMPHASIS_EN
    // emph is {B,G,R}; a clear bit dims its channel to 3/4 when any bit is set.
    if (!s1_raw_q && s1_emph_q != 3'b000) begin
      if (!s1_emph_q[0]) color[2*CB +: CB] = atten(color[2*CB +: CB]);
      if (!s1_emph_q[1]) color[CB +: CB]   = atten(color[CB +: CB]);
      if (!s1_emph_q[2]) color[0 +: CB]    = atten(color[0 +: CB]);
    end
`endif

    rgb_valid_d = s1_valid_q;
    rgb_d       = s1_valid_q ? color  : rgb_q;
    px_x_d      = s1_valid_q ? s1_x_q : px_x_q;
    px_y_d      = s1_valid_q ? s1_y_q : px_y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_cnt_q  <= '0;
      mode_q       <= '0;
      bank_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_raw_q     <= 1'b0;
      s1_idx_q     <= '0;
      s1_raw_rgb_q <= '0;
      s1_bank_q    <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
`ifdef EMPHASIS_EN
      s1_emph_q    <= '0;
`endif
      rgb_q        <= '0;
      rgb_valid_q  <= 1'b0;
      px_x_q       <= '0;
      px_y_q       <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_cnt_q  <= frame_cnt_d;
      mode_q       <= mode_d;
      bank_q       <= bank_d;
      s1_valid_q   <= s1_valid_d;
      s1_raw_q     <= s1_raw_d;
      s1_idx_q     <= s1_idx_d;
      s1_raw_rgb_q <= s1_raw_rgb_d;
      s1_bank_q    <= s1_bank_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
`ifdef EMPHASIS_EN
      s1_emph_q    <= s1_emph_d;
`endif
      rgb_q        <= rgb_d;
      rgb_valid_q  <= rgb_valid_d;
      px_x_q       <= px_x_d;
      px_y_q       <= px_y_d;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.rgb_valid = rgb_valid_q;
  assign bus.px_x      = px_x_q;
  assign bus.px_y      = px_y_q;
endmodule

// File: tb/tb_ppu_pixel_pipe.sv
// tb/tb_ppu_pixel_pipe.sv - directed self-checking bench for ppu_pixel_pipe
module tb_ppu_pixel_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

`ifdef EMPHASIS_EN
  localparam logic [23:0] EMPH_EXP = 24'h806060;
`else
  localparam logic [23:0] EMPH_EXP = 24'h808080;
`endif

  ppu_pixel_pipe_if bus ();
  ppu_pixel_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [23:0] d);
    bus.pal_we = 1'b1; bus.pal_waddr = a; bus.pal_wdata = d;
    step();
    bus.pal_we = 1'b0;
  endtask

  task automatic fsync(input logic [2:0] m, input logic b);
    bus.mode_req = m; bus.pal_sel_req = b; bus.frame_sync = 1'b1;
    step();
    bus.frame_sync = 1'b0;
  endtask

  task automatic stream(input int n);
    bus.px_en = 1'b1; bus.px_data = 6'h16;
    repeat (n) step();
    bus.px_en = 1'b0;
    step();
    step();
  endtask

  task automatic pix_chk(input string tag, input logic [5:0] d, input logic fs, input logic [2:0] e,
                         input logic [23:0] exp_rgb, input logic [8:0] ex, input logic [8:0] ey);
    bus.px_en = 1'b1; bus.px_data = d; bus.frame_sync = fs; bus.emph = e;
    step();
    bus.px_en = 1'b0; bus.frame_sync = 1'b0; bus.emph = 3'b000;
    step();
    chk({tag, "_valid"}, 32'(bus.rgb_valid), 32'd1);
    chk({tag, "_rgb"}, 32'(bus.rgb), 32'(exp_rgb));
    chk({tag, "_x"}, 32'(bus.px_x), 32'(ex));
    chk({tag, "_y"}, 32'(bus.px_y), 32'(ey));
  endtask

  initial begin
    bus.px_en = 1'b0; bus.px_data = '0; bus.emph = '0; bus.frame_sync = 1'b0;
    bus.mode_req = '0; bus.pal_sel_req = '0; bus.test_color = '0;
    bus.pal_we = 1'b0; bus.pal_waddr = '0; bus.pal_wdata = '0;

    for (int i = 0; i < 4; i++) begin
      bus.px_en = i[0];
      step();
      chk("rst_valid", 32'(bus.rgb_valid), 32'd0);
      chk("rst_rgb", 32'(bus.rgb), 32'd0);
    end
    bus.px_en = 1'b0;
    rst_n = 1'b1;
    step();

    wr(7'h16, 24'hB53120);
    wr(7'h56, 24'h00FF00);
    wr(7'h20, 24'h808080);
    wr(7'h30, 24'hFFFFFF);
    wr(7'h0F, 24'h000001);
    wr(7'h05, 24'h050505);
    wr(7'h00, 24'h0A0B0C);
    wr(7'h08, 24'h111111);

    // px_en at t: valid only at t+2, then holds last pixel
    bus.px_en = 1'b1; bus.px_data = 6'h16;
    step();
    bus.px_en = 1'b0;
    chk("lat_t1_valid", 32'(bus.rgb_valid), 32'd0);
    step();
    chk("lat_t2_valid", 32'(bus.rgb_valid), 32'd1);
    chk("lat_t2_rgb", 32'(bus.rgb), 32'hB53120);
    chk("lat_t2_x", 32'(bus.px_x), 32'd0);
    step();
    chk("lat_t3_valid", 32'(bus.rgb_valid), 32'd0);
    chk("hold_rgb", 32'(bus.rgb), 32'hB53120);

    bus.px_en = 1'b1; bus.px_data = 6'h16;
    step();
    bus.px_data = 6'h20;
    step();
    bus.px_en = 1'b0;
    chk("b2b_a_valid", 32'(bus.rgb_valid), 32'd1);
    chk("b2b_a_rgb", 32'(bus.rgb), 32'hB53120);
    chk("b2b_a_x", 32'(bus.px_x), 32'd1);
    step();
    chk("b2b_b_valid", 32'(bus.rgb_valid), 32'd1);
    chk("b2b_b_rgb", 32'(bus.rgb), 32'h808080);
    chk("b2b_b_x", 32'(bus.px_x), 32'd2);
    step();
    chk("b2b_end_valid", 32'(bus.rgb_valid), 32'd0);

    fsync(3'd0, 1'b0);
    bus.pal_sel_req = 1'b1;
    pix_chk("bank_old", 6'h16, 1'b0, 3'b000, 24'hB53120, 9'd0, 9'd0);
    pix_chk("bank_new", 6'h16, 1'b1, 3'b000, 24'h00FF00, 9'd0, 9'd0);
    pix_chk("bank_x1", 6'h16, 1'b0, 3'b000, 24'h00FF00, 9'd1, 9'd0);

    bus.px_en = 1'b1; bus.px_data = 6'h16;
    step();
    bus.px_en = 1'b0;
    bus.pal_we = 1'b1; bus.pal_waddr = 7'h56; bus.pal_wdata = 24'h123456;
    step();
    bus.pal_we = 1'b0;
    chk("rdfirst_rgb", 32'(bus.rgb), 32'h00FF00);
    pix_chk("rdfirst_new", 6'h16, 1'b0, 3'b000, 24'h123456, 9'd3, 9'd0);

    fsync(3'd0, 1'b0);
    pix_chk("emph", 6'h20, 1'b0, 3'b001, EMPH_EXP, 9'd0, 9'd0);
    fsync(3'd6, 1'b0);
    pix_chk("mode6", 6'h16, 1'b0, 3'b000, 24'hB53120, 9'd0, 9'd0);
    fsync(3'd1, 1'b0);
    pix_chk("raw", 6'b100111, 1'b0, 3'b001, 24'h8040C0, 9'd0, 9'd0);
    fsync(3'd2, 1'b0);
    bus.test_color = 6'h16;
    pix_chk("solid", 6'h05, 1'b0, 3'b000, 24'hB53120, 9'd0, 9'd0);
    bus.mode_req = 3'd3;
    pix_chk("bars_x0", 6'h16, 1'b1, 3'b000, 24'h0A0B0C, 9'd0, 9'd0);
    stream(31);
    pix_chk("bars_x32", 6'h16, 1'b0, 3'b000, 24'h111111, 9'd32, 9'd0);

    // reset with a pixel in flight: nothing may emerge afterwards
    bus.px_en = 1'b1;
    step();
    bus.px_en = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_valid1", 32'(bus.rgb_valid), 32'd0);
    step();
    chk("midrst_valid2", 32'(bus.rgb_valid), 32'd0);
    chk("midrst_rgb", 32'(bus.rgb), 32'd0);

    fsync(3'd5, 1'b0);
    fsync(3'd5, 1'b0);
    fsync(3'd5, 1'b0);
    stream(8);
    pix_chk("scroll", 6'h16, 1'b0, 3'b000, 24'h050505, 9'd8, 9'd0);

    fsync(3'd4, 1'b0);
    stream(256 * 5 + 16);
    pix_chk("grid_white", 6'h16, 1'b0, 3'b000, 24'hFFFFFF, 9'd16, 9'd5);
    pix_chk("grid_black", 6'h16, 1'b0, 3'b000, 24'h000001, 9'd17, 9'd5);

    fsync(3'd0, 1'b0);
    stream(256 * 240 - 1);
    pix_chk("frame_last", 6'h16, 1'b0, 3'b000, 24'hB53120, 9'd255, 9'd239);
    pix_chk("frame_first", 6'h16, 1'b1, 3'b000, 24'hB53120, 9'd0, 9'd0);
    pix_chk("frame_next", 6'h16, 1'b0, 3'b000, 24'hB53120, 9'd1, 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
